// File: rtl/timer_responder_pkg.sv
// Shared encodings for the memory-mapped countdown timer: FSM states,
// register word offsets, CTRL layout and MODE values.
package timer_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } tmr_state_e;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IM_BIT   = 3;
    localparam int CTRL_W        = 4;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

    // Packed so that the struct maps directly onto CTRL[3:0].
    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

endpackage

// File: rtl/timer_responder_be_merge.sv
// Byte-lane merge of store data into an existing word; shared with the
// DM byte-store path.
module be_merge (
    input  logic [31:0] old_i,
    input  logic [31:0] wd_i,
    input  logic [3:0]  be_i,
    output logic [31:0] merged_o
);

    always_comb begin
        merged_o = old_i;
        for (int i = 0; i < 4; i++) begin
            if (be_i[i]) begin
                merged_o[8*i +: 8] = wd_i[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/timer_responder.sv
// Countdown timer responder on the M-stage data bus: combinational reads,
// byte-enabled stores, one-shot or auto-reload expiry with a registered irq.
module timer_responder
    import timer_responder_pkg::*;
#(
    parameter int COUNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [3:0]  be,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        irq
);

    tmr_state_e         state_q, state_d;
    ctrl_t              ctrl_q, ctrl_d;
    logic [COUNT_W-1:0] preset_q, preset_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               pending_q, pending_d;
    logic               irq_q, irq_d;

    logic [31:0] reg_word;
    logic [31:0] merged;
    logic        ctrl_wr;
    logic        preset_wr;
    ctrl_t       ctrl_wr_val;

    always_comb begin
        case (addr)
            ADDR_CTRL:   reg_word = {{(32-CTRL_W){1'b0}}, ctrl_q};
            ADDR_PRESET: reg_word = 32'(preset_q);
            ADDR_COUNT:  reg_word = 32'(count_q);
            default:     reg_word = 32'd0;
        endcase
    end

    assign rd = sel ? reg_word : 32'd0;
    assign irq = irq_q;

    be_merge u_be_merge (
        .old_i    (reg_word),
        .wd_i     (wd),
        .be_i     (be),
        .merged_o (merged)
    );

    assign ctrl_wr     = sel & we & (addr == ADDR_CTRL) & (|be);
    assign preset_wr   = sel & we & (addr == ADDR_PRESET) & (|be);
    assign ctrl_wr_val = ctrl_t'(merged[CTRL_W-1:0]);

    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_wr ? ctrl_wr_val : ctrl_q;
        preset_d  = preset_wr ? COUNT_W'(merged) : preset_q;
        count_d   = count_q;
        pending_d = pending_q;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_q.en) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Ends an auto-reload pulse; a one-shot pending was already
                // cleared by the CTRL write that re-enabled the timer.
                count_d   = preset_q;
                pending_d = 1'b0;
                state_d   = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_d.en) begin
                    state_d = ST_IDLE;
                end else if (count_q > COUNT_W'(1)) begin
                    count_d = count_q - COUNT_W'(1);
                end else begin
                    count_d = '0;
                    state_d = ST_INT;
                end
            end
            ST_INT: begin
                pending_d = 1'b1;
                if (ctrl_q.mode == MODE_RELOAD) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                    if (!ctrl_wr) begin
                        ctrl_d.en = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (ctrl_wr) begin
            pending_d = 1'b0;
        end

        irq_d = ctrl_d.im & pending_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ctrl_q    <= '0;
            preset_q  <= '0;
            count_q   <= '0;
            pending_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            irq_q     <= irq_d;
        end
    end

endmodule

// File: tb/tb_timer_responder.sv
// Scoreboard bench for timer_responder: directed scenarios plus random bus
// traffic, checked against a behavioural model of the timer.
module tb_timer_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        irq;

    always #5 clk = ~clk;

    timer_responder #(.COUNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .we    (we),
        .addr  (addr),
        .be    (be),
        .wd    (wd),
        .rd    (rd),
        .irq   (irq)
    );

    typedef struct {
        logic [31:0] rd;
        logic        irq;
        logic [1:0]  addr;
        int          tag;
    } exp_t;

    exp_t sb_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   tag_cnt = 0;

    // Behavioural model: what software would observe, in the timer's own terms.
    typedef enum int {P_IDLE, P_LOAD, P_RUN, P_EXPIRE} phase_e;
    phase_e      m_phase;
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    bit          m_pending;
    bit          m_pulse;
    bit          m_irq;

    function automatic logic [31:0] merge32(input logic [31:0] old, input logic [31:0] d,
                                            input logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++)
            if (b[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic void model_reset();
        m_phase = P_IDLE; m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0;
        m_pending = 0; m_pulse = 0; m_irq = 0;
    endfunction

    function automatic logic [31:0] model_rd(input bit s, input logic [1:0] a);
        if (!s) return 32'd0;
        case (a)
            2'd0: return {28'd0, m_ctrl};
            2'd1: return m_preset;
            2'd2: return m_count;
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_edge(input bit r, input bit s, input bit w,
                                       input logic [1:0] a, input logic [3:0] b,
                                       input logic [31:0] d);
        logic [3:0]  nctrl;
        logic [31:0] npreset, ncount, tmp;
        bit          npend, npulse, touch;
        phase_e      nphase;
        if (r) begin
            model_reset();
            return;
        end
        touch   = s && w && (a == 2'd0) && (b != 4'd0);
        nctrl   = m_ctrl;
        npreset = m_preset;
        if (touch) begin
            tmp = merge32({28'd0, m_ctrl}, d, b);
            nctrl = tmp[3:0];
        end
        if (s && w && a == 2'd1) npreset = merge32(m_preset, d, b);
        ncount = m_count;
        nphase = m_phase;
        npend  = m_pulse ? 1'b0 : m_pending;
        npulse = 0;
        case (m_phase)
            P_IDLE: if (m_ctrl[0]) nphase = P_LOAD;
            P_LOAD: begin ncount = m_preset; nphase = P_RUN; end
            P_RUN: begin
                if (!nctrl[0]) nphase = P_IDLE;
                else if (m_count > 1) ncount = m_count - 1;
                else begin ncount = 0; nphase = P_EXPIRE; end
            end
            P_EXPIRE: begin
                npend = 1;
                if (m_ctrl[2:1] == 2'd1) begin
                    nphase = P_LOAD; npulse = 1;
                end else begin
                    nphase = P_IDLE;
                    if (!touch) nctrl[0] = 1'b0;
                end
            end
            default: nphase = P_IDLE;
        endcase
        if (touch) begin npend = 0; npulse = 0; end
        m_ctrl = nctrl; m_preset = npreset; m_count = ncount; m_phase = nphase;
        m_pending = npend; m_pulse = npulse;
        m_irq = nctrl[3] && npend;
    endfunction

    // Called just after a rising edge: drive, record expectation, advance.
    task automatic step(input bit r, input bit s, input bit w, input logic [1:0] a,
                        input logic [3:0] b, input logic [31:0] d);
        exp_t e;
        reset = r; sel = s; we = w; addr = a; be = b; wd = d;
        e.rd = model_rd(s, a); e.irq = m_irq; e.addr = a; e.tag = tag_cnt++;
        sb_q.push_back(e);
        @(posedge clk);
        model_edge(r, s, w, a, b, d);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] b, input logic [31:0] d);
        step(0, 1, 1, a, b, d);
    endtask

    task automatic rdreg(input logic [1:0] a, input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, a, 4'd0, 32'd0);
    endtask

    task automatic read_until_count(input logic [31:0] v, input int maxc);
        int i;
        for (i = 0; i < maxc && m_count != v; i++) rdreg(2'd2, 1);
        if (m_count != v) begin
            miscompares++;
            $display("FAIL count_wait: got %0d required %0d within %0d cycles", m_count, v, maxc);
        end
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                vectors++;
                if (rd !== e.rd) begin
                    miscompares++;
                    $display("FAIL rd vec=%0d addr=%0d: got %h required %h", e.tag, e.addr, rd, e.rd);
                end
                if (irq !== e.irq) begin
                    miscompares++;
                    $display("FAIL irq vec=%0d: got %b required %b", e.tag, irq, e.irq);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int op;
        logic [31:0] d;
        reset = 1; sel = 0; we = 0; addr = 0; be = 0; wd = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // reset values
        rdreg(2'd0, 1); rdreg(2'd1, 1); rdreg(2'd2, 1); rdreg(2'd3, 1);

        // one-shot with IM, then clear by CTRL write
        wr(2'd1, 4'hF, 32'd5);
        wr(2'd0, 4'hF, 32'h9);
        rdreg(2'd2, 12);
        rdreg(2'd0, 2);
        wr(2'd0, 4'h1, 32'h8);
        rdreg(2'd0, 3);

        // auto-reload
        wr(2'd1, 4'hF, 32'd3);
        wr(2'd0, 4'hF, 32'hB);
        rdreg(2'd2, 18);
        wr(2'd0, 4'hF, 32'h0);
        rdreg(2'd2, 3);

        // stop mid-count, then PRESET written during a run
        wr(2'd1, 4'hF, 32'd6);
        wr(2'd0, 4'hF, 32'h9);
        read_until_count(32'd2, 20);
        wr(2'd0, 4'hF, 32'h0);
        rdreg(2'd2, 6);
        wr(2'd0, 4'hF, 32'h9);
        rdreg(2'd2, 4);
        wr(2'd1, 4'hF, 32'd2);
        rdreg(2'd2, 10);
        rdreg(2'd1, 1);
        wr(2'd0, 4'hF, 32'h8);

        // byte lanes, read-only COUNT, reserved word, deselected store
        wr(2'd1, 4'hF, 32'h11223344);
        wr(2'd1, 4'b0100, 32'h00AB0000);
        rdreg(2'd1, 1);
        wr(2'd1, 4'b1100, 32'hCAFE0000);
        wr(2'd1, 4'b0000, 32'hFFFFFFFF);
        rdreg(2'd1, 1);
        wr(2'd2, 4'hF, 32'hFFFFFFFF);
        rdreg(2'd2, 1);
        wr(2'd3, 4'hF, 32'hFFFFFFFF);
        rdreg(2'd3, 1);
        step(0, 0, 1, 2'd1, 4'hF, 32'h0);
        rdreg(2'd1, 1);
        wr(2'd0, 4'hF, 32'hFFFFFFF0);
        rdreg(2'd0, 1);

        // reset mid-count and with pending set, then PRESET=0
        wr(2'd1, 4'hF, 32'd4);
        wr(2'd0, 4'hF, 32'hB);
        rdreg(2'd2, 5);
        step(1, 0, 0, 2'd0, 4'd0, 32'd0);
        rdreg(2'd0, 2); rdreg(2'd2, 1);
        wr(2'd1, 4'hF, 32'd1);
        wr(2'd0, 4'hF, 32'h9);
        rdreg(2'd2, 7);
        step(1, 0, 0, 2'd0, 4'd0, 32'd0);
        rdreg(2'd0, 2);
        wr(2'd1, 4'hF, 32'd0);
        wr(2'd0, 4'hF, 32'h9);
        rdreg(2'd2, 6);
        wr(2'd0, 4'hF, 32'h0);

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            op = $urandom_range(0, 99);
            if (op < 2) begin
                step(1, 0, 0, 2'd0, 4'd0, 32'd0);
            end else if (op < 12) begin
                d = $urandom;
                d[0] = ($urandom_range(0, 3) != 0);
                wr(2'd0, ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'h1, d);
            end else if (op < 18) begin
                if ($urandom_range(0, 9) == 0) wr(2'd1, 4'($urandom), $urandom);
                else wr(2'd1, 4'hF, 32'($urandom_range(0, 6)));
            end else if (op < 21) begin
                wr(2'($urandom_range(2, 3)), 4'($urandom), $urandom);
            end else if (op < 24) begin
                step(0, 0, 1, 2'($urandom), 4'($urandom), $urandom);
            end else begin
                step(0, ($urandom_range(0, 4) != 0), 0, 2'($urandom), 4'd0, 32'd0);
            end
        end

        @(negedge clk);
        @(negedge clk);
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
